// File: rtl/sd_frame_loader.sv
// sd_frame_loader
// Streams bytes from an SD card reader into one of several image slots held
// in a pixel RAM, and hands a completed slot to the display at the next
// vertical blank.
//
// Ports
//   clk, rst_n     single rising-edge clock, asynchronous active-low reset
//   start          one-cycle load request; slot_sel is sampled with it
//   slot_sel       target slot for the load
//   abort          cancels a load in progress
//   in_data        byte from the SD reader, qualified by in_valid
//   in_valid       byte strobe (no backpressure)
//   frame_sync     vertical-blank pulse from the display
//   ram_addr       RAM write address (registered)
//   ram_data       RAM write data (registered)
//   ram_we         one-cycle RAM write strobe per completed pixel
//   busy           high while loading
//   done           one-cycle pulse when a slot has been fully loaded
//   err            sticky timeout / bad-slot flag, cleared by a valid start
//   loaded_mask    bit i set when slot i holds a complete image
//   display_slot   slot currently shown by the display

module sd_frame_loader #(
    parameter int PIX_W       = 16,
    parameter int ADDR_W      = 17,
    parameter int NUM_SLOTS   = 4,
    parameter int SLOT_PIXELS = 19200,
    parameter int MSB_FIRST   = 1,
    parameter int TIMEOUT_CYC = 1000000,
    localparam int SLOT_W     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [SLOT_W-1:0]    slot_sel,
    input  logic                 abort,
    input  logic [7:0]           in_data,
    input  logic                 in_valid,
    input  logic                 frame_sync,
    output logic [ADDR_W-1:0]    ram_addr,
    output logic [PIX_W-1:0]     ram_data,
    output logic                 ram_we,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [NUM_SLOTS-1:0] loaded_mask,
    output logic [SLOT_W-1:0]    display_slot
);

    localparam int BPP    = PIX_W / 8;
    localparam int BIDX_W = (BPP > 1) ? $clog2(BPP) : 1;
    localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE,
        ERR
    } state_t;

    state_t              state;
    logic [SLOT_W-1:0]   slot_q;
    logic [ADDR_W-1:0]   base;
    logic [ADDR_W-1:0]   pix_cnt;
    logic [BIDX_W-1:0]   byte_idx;
    logic [PIX_W-1:0]    pix_acc;
    logic [IDLE_W-1:0]   idle_cnt;
    logic [SLOT_W-1:0]   pending_slot;
    logic                pending_valid;

    logic [PIX_W-1:0]    next_acc;
    logic                slot_ok;
    logic                last_byte;
    logic                last_pix;

    // Pixel assembly: with MSB_FIRST the accumulator shifts left so the first
    // byte ends up on top; otherwise it shifts right so the first byte ends
    // up at the bottom. After BPP bytes the whole register is the pixel.
    always_comb begin
        next_acc = '0;
        if (MSB_FIRST != 0) begin
            next_acc = (pix_acc << 8) | PIX_W'(in_data);
        end else begin
            next_acc = (pix_acc >> 8) | (PIX_W'(in_data) << (PIX_W - 8));
        end
        slot_ok   = 32'(slot_sel) < NUM_SLOTS;
        last_byte = (byte_idx == BIDX_W'(BPP - 1));
        last_pix  = (pix_cnt == ADDR_W'(SLOT_PIXELS - 1));
    end

    // Main controller. frame_sync is handled before the state case so that
    // the DONE branch, which publishes the new pending slot, overrides the
    // pending clear: a vblank coinciding with DONE consumes the old pending
    // state and the fresh slot waits for the following vblank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            slot_q        <= '0;
            base          <= '0;
            pix_cnt       <= '0;
            byte_idx      <= '0;
            pix_acc       <= '0;
            idle_cnt      <= '0;
            pending_slot  <= '0;
            pending_valid <= 1'b0;
            ram_addr      <= '0;
            ram_data      <= '0;
            ram_we        <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            loaded_mask   <= '0;
            display_slot  <= '0;
        end else begin
            ram_we <= 1'b0;
            done   <= 1'b0;

            if (frame_sync && pending_valid) begin
                display_slot  <= pending_slot;
                pending_valid <= 1'b0;
            end

            case (state)
                IDLE, ERR: begin
                    if (start) begin
                        if (slot_ok) begin
                            state                 <= LOAD;
                            busy                  <= 1'b1;
                            err                   <= 1'b0;
                            slot_q                <= slot_sel;
                            base                  <= ADDR_W'(slot_sel) * ADDR_W'(SLOT_PIXELS);
                            pix_cnt               <= '0;
                            byte_idx              <= '0;
                            pix_acc               <= '0;
                            idle_cnt              <= '0;
                            loaded_mask[slot_sel] <= 1'b0;
                        end else begin
                            state <= ERR;
                            err   <= 1'b1;
                        end
                    end
                end

                // Abort beats a simultaneous byte; a write already issued on
                // the previous edge still completes because ram_we is a
                // registered one-cycle pulse.
                LOAD: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (in_valid) begin
                        idle_cnt <= '0;
                        pix_acc  <= next_acc;
                        byte_idx <= last_byte ? '0 : byte_idx + 1'b1;
                        if (last_byte) begin
                            ram_we   <= 1'b1;
                            ram_addr <= base + pix_cnt;
                            ram_data <= next_acc;
                            pix_cnt  <= pix_cnt + 1'b1;
                            if (last_pix) begin
                                state               <= DONE;
                                busy                <= 1'b0;
                                done                <= 1'b1;
                                loaded_mask[slot_q] <= 1'b1;
                            end
                        end
                    end else if (idle_cnt == IDLE_W'(TIMEOUT_CYC - 1)) begin
                        state <= ERR;
                        busy  <= 1'b0;
                        err   <= 1'b1;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end

                DONE: begin
                    state         <= IDLE;
                    pending_slot  <= slot_q;
                    pending_valid <= 1'b1;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_frame_loader.sv
// tb_sd_frame_loader
// Directed bench for sd_frame_loader. Three instances share clock and reset:
//   dut_a  default parameters (full 19200-pixel slot load)
//   dut_b  24-bit LSB-first pixels, 3 slots of 64 pixels, 16-cycle timeout
//   dut_c  16-bit pixels, 1000-pixel slots (abort, vblank hand-off, reset)

module tb_sd_frame_loader;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // dut_a signals
    logic        a_start, a_abort, a_valid, a_fs;
    logic [1:0]  a_slot;
    logic [7:0]  a_data;
    logic [16:0] a_addr;
    logic [15:0] a_wdata;
    logic        a_we, a_busy, a_done, a_err;
    logic [3:0]  a_mask;
    logic [1:0]  a_disp;

    // dut_b signals
    logic        b_start, b_abort, b_valid, b_fs;
    logic [1:0]  b_slot;
    logic [7:0]  b_data;
    logic [16:0] b_addr;
    logic [23:0] b_wdata;
    logic        b_we, b_busy, b_done, b_err;
    logic [2:0]  b_mask;
    logic [1:0]  b_disp;

    // dut_c signals
    logic        c_start, c_abort, c_valid, c_fs;
    logic [1:0]  c_slot;
    logic [7:0]  c_data;
    logic [16:0] c_addr;
    logic [15:0] c_wdata;
    logic        c_we, c_busy, c_done, c_err;
    logic [3:0]  c_mask;
    logic [1:0]  c_disp;

    sd_frame_loader dut_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .slot_sel(a_slot),
        .abort(a_abort), .in_data(a_data), .in_valid(a_valid),
        .frame_sync(a_fs), .ram_addr(a_addr), .ram_data(a_wdata),
        .ram_we(a_we), .busy(a_busy), .done(a_done), .err(a_err),
        .loaded_mask(a_mask), .display_slot(a_disp)
    );

    sd_frame_loader #(
        .PIX_W(24), .MSB_FIRST(0), .NUM_SLOTS(3), .SLOT_PIXELS(64),
        .TIMEOUT_CYC(16)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .slot_sel(b_slot),
        .abort(b_abort), .in_data(b_data), .in_valid(b_valid),
        .frame_sync(b_fs), .ram_addr(b_addr), .ram_data(b_wdata),
        .ram_we(b_we), .busy(b_busy), .done(b_done), .err(b_err),
        .loaded_mask(b_mask), .display_slot(b_disp)
    );

    sd_frame_loader #(
        .SLOT_PIXELS(1000)
    ) dut_c (
        .clk(clk), .rst_n(rst_n), .start(c_start), .slot_sel(c_slot),
        .abort(c_abort), .in_data(c_data), .in_valid(c_valid),
        .frame_sync(c_fs), .ram_addr(c_addr), .ram_data(c_wdata),
        .ram_we(c_we), .busy(c_busy), .done(c_done), .err(c_err),
        .loaded_mask(c_mask), .display_slot(c_disp)
    );

    // Write/done monitors, sampled on the falling edge. dut_a writes must
    // form the contiguous slot-2 address run with the fixed 0xABCD pattern.
    int a_writes = 0, a_seq_bad = 0, a_dones = 0;
    int c_writes = 0, c_dones = 0;

    always @(negedge clk) begin
        if (a_we) begin
            if (a_addr !== 17'(38400 + a_writes) || a_wdata !== 16'hABCD)
                a_seq_bad++;
            a_writes++;
        end
        if (a_done) a_dones++;
        if (c_we) c_writes++;
        if (c_done) c_dones++;
    end

    typedef struct {
        logic [1:0]  slot;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [16:0] addr;
        logic [15:0] data;
    } vec_t;

    vec_t vecs[5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One table row on dut_c: start, two bytes, check the write, abort.
    task automatic apply_stimulus(input vec_t v);
        c_start = 1'b1;
        c_slot  = v.slot;
        tick();
        c_start = 1'b0;
        check_output("vec busy after start", 32'(c_busy), 32'd1);
        c_valid = 1'b1;
        c_data  = v.b0;
        tick();
        check_output("vec no write on half pixel", 32'(c_we), 32'd0);
        c_data = v.b1;
        tick();
        c_valid = 1'b0;
        check_output("vec ram_we", 32'(c_we), 32'd1);
        check_output("vec ram_addr", 32'(c_addr), 32'(v.addr));
        check_output("vec ram_data", 32'(c_wdata), 32'(v.data));
        c_abort = 1'b1;
        tick();
        c_abort = 1'b0;
        check_output("vec busy after abort", 32'(c_busy), 32'd0);
        tick();
    endtask

    // Full dut_c slot load; returns just after the edge of the last byte.
    task automatic load_c(input logic [1:0] slot);
        c_start = 1'b1;
        c_slot  = slot;
        tick();
        c_start = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            c_valid = 1'b1;
            c_data  = k[7:0];
            tick();
        end
        c_valid = 1'b0;
    endtask

    int w0, d0;

    initial begin
        vecs[0] = '{slot: 2'd0, b0: 8'h12, b1: 8'h34, addr: 17'd0,    data: 16'h1234};
        vecs[1] = '{slot: 2'd1, b0: 8'hFF, b1: 8'h00, addr: 17'd1000, data: 16'hFF00};
        vecs[2] = '{slot: 2'd2, b0: 8'h00, b1: 8'hA5, addr: 17'd2000, data: 16'h00A5};
        vecs[3] = '{slot: 2'd3, b0: 8'h5A, b1: 8'hC3, addr: 17'd3000, data: 16'h5AC3};
        vecs[4] = '{slot: 2'd1, b0: 8'h80, b1: 8'h01, addr: 17'd1000, data: 16'h8001};

        {a_start, a_abort, a_valid, a_fs, a_slot, a_data} = '0;
        {b_start, b_abort, b_valid, b_fs, b_slot, b_data} = '0;
        {c_start, c_abort, c_valid, c_fs, c_slot, c_data} = '0;
        rst_n = 1'b0;
        tick();
        tick();

        // Reset state
        check_output("reset ram_we", 32'(a_we), 32'd0);
        check_output("reset ram_addr", 32'(a_addr), 32'd0);
        check_output("reset ram_data", 32'(a_wdata), 32'd0);
        check_output("reset busy", 32'(a_busy), 32'd0);
        check_output("reset done", 32'(a_done), 32'd0);
        check_output("reset err", 32'(a_err), 32'd0);
        check_output("reset loaded_mask", 32'(a_mask), 32'd0);
        check_output("reset display_slot", 32'(a_disp), 32'd0);
        rst_n = 1'b1;
        tick();

        // Full default load into slot 2
        a_start = 1'b1;
        a_slot  = 2'd2;
        tick();
        a_start = 1'b0;
        for (int k = 0; k < 38400; k++) begin
            a_valid = 1'b1;
            a_data  = k[0] ? 8'hCD : 8'hAB;
            tick();
            if (k == 1000) check_output("a busy mid load", 32'(a_busy), 32'd1);
        end
        check_output("a done on last write", 32'(a_done), 32'd1);
        check_output("a busy after done", 32'(a_busy), 32'd0);
        for (int k = 0; k < 6; k++) begin
            a_data = 8'h55;
            tick();
        end
        a_valid = 1'b0;
        tick();
        check_output("a write count", 32'(a_writes), 32'd19200);
        check_output("a addr/data sequence errors", 32'(a_seq_bad), 32'd0);
        check_output("a done count", 32'(a_dones), 32'd1);
        check_output("a loaded_mask", 32'(a_mask), 32'b0100);

        // LSB-first 24-bit pixel into slot 0
        b_start = 1'b1;
        b_slot  = 2'd0;
        tick();
        b_start = 1'b0;
        b_valid = 1'b1;
        b_data  = 8'h11;
        tick();
        b_data = 8'h22;
        tick();
        check_output("b no write before third byte", 32'(b_we), 32'd0);
        b_data = 8'h33;
        tick();
        b_valid = 1'b0;
        check_output("b ram_we after 0x33", 32'(b_we), 32'd1);
        check_output("b ram_addr", 32'(b_addr), 32'd0);
        check_output("b ram_data", 32'(b_wdata), 32'h332211);

        // Timeout: 16 idle cycles after the third byte
        for (int k = 0; k < 15; k++) tick();
        check_output("b err before timeout", 32'(b_err), 32'd0);
        check_output("b busy before timeout", 32'(b_busy), 32'd1);
        tick();
        check_output("b err at timeout", 32'(b_err), 32'd1);
        check_output("b busy in ERR", 32'(b_busy), 32'd0);
        b_valid = 1'b1;
        b_data  = 8'h77;
        tick();
        b_valid = 1'b0;
        check_output("b no write in ERR", 32'(b_we), 32'd0);
        b_start = 1'b1;
        b_slot  = 2'd0;
        tick();
        b_start = 1'b0;
        check_output("b err cleared by start", 32'(b_err), 32'd0);
        check_output("b busy after restart", 32'(b_busy), 32'd1);
        b_abort = 1'b1;
        tick();
        b_abort = 1'b0;

        // Out-of-range slot, then recovery into slot 2
        b_start = 1'b1;
        b_slot  = 2'd3;
        tick();
        b_start = 1'b0;
        check_output("b err on bad slot", 32'(b_err), 32'd1);
        check_output("b busy on bad slot", 32'(b_busy), 32'd0);
        b_start = 1'b1;
        b_slot  = 2'd2;
        tick();
        b_start = 1'b0;
        check_output("b err cleared slot 2", 32'(b_err), 32'd0);
        b_valid = 1'b1;
        b_data  = 8'hAA;
        tick();
        b_data = 8'hBB;
        tick();
        b_data = 8'hCC;
        tick();
        b_valid = 1'b0;
        check_output("b slot 2 ram_addr", 32'(b_addr), 32'd128);
        check_output("b slot 2 ram_data", 32'(b_wdata), 32'hCCBBAA);
        b_abort = 1'b1;
        tick();
        b_abort = 1'b0;

        // Table-driven first-pixel vectors on dut_c
        foreach (vecs[i]) apply_stimulus(vecs[i]);

        // Slot 3 completes; vblank coinciding with done acts on old pending
        check_output("c display_slot before", 32'(c_disp), 32'd0);
        load_c(2'd3);
        check_output("c done slot 3", 32'(c_done), 32'd1);
        c_fs = 1'b1;
        tick();
        c_fs = 1'b0;
        check_output("c display on coincident sync", 32'(c_disp), 32'd0);
        check_output("c done is one cycle", 32'(c_done), 32'd0);
        tick();
        tick();
        c_fs = 1'b1;
        tick();
        c_fs = 1'b0;
        check_output("c display after next sync", 32'(c_disp), 32'd3);
        check_output("c mask slot 3", 32'(c_mask), 32'b1000);

        // Load slot 1, then reload and abort after 100 bytes
        load_c(2'd1);
        tick();
        check_output("c mask slot 1 loaded", 32'(c_mask), 32'b1010);
        d0 = c_dones;
        c_start = 1'b1;
        c_slot  = 2'd1;
        tick();
        c_start = 1'b0;
        check_output("c mask cleared on start", 32'(c_mask), 32'b1000);
        w0 = c_writes;
        for (int k = 0; k < 100; k++) begin
            c_valid = 1'b1;
            c_data  = k[7:0];
            tick();
        end
        check_output("c busy before abort", 32'(c_busy), 32'd1);
        c_abort = 1'b1;
        c_data  = 8'hEE;
        tick();
        c_abort = 1'b0;
        c_valid = 1'b0;
        check_output("c busy after abort", 32'(c_busy), 32'd0);
        tick();
        tick();
        tick();
        check_output("c writes before abort", 32'(c_writes - w0), 32'd50);
        check_output("c no done on abort", 32'(c_dones - d0), 32'd0);
        check_output("c mask after abort", 32'(c_mask), 32'b1000);

        // Reset pulse mid-load around pixel 500
        c_start = 1'b1;
        c_slot  = 2'd0;
        tick();
        c_start = 1'b0;
        for (int k = 0; k < 1001; k++) begin
            c_valid = 1'b1;
            c_data  = k[7:0];
            tick();
        end
        rst_n = 1'b0;
        #1;
        check_output("async reset ram_we", 32'(c_we), 32'd0);
        check_output("async reset ram_addr", 32'(c_addr), 32'd0);
        check_output("async reset ram_data", 32'(c_wdata), 32'd0);
        check_output("async reset busy", 32'(c_busy), 32'd0);
        check_output("async reset loaded_mask", 32'(c_mask), 32'd0);
        check_output("async reset display_slot", 32'(c_disp), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        w0 = c_writes;
        for (int k = 0; k < 20; k++) begin
            c_data = k[7:0];
            tick();
        end
        c_valid = 1'b0;
        tick();
        check_output("no writes after reset release", 32'(c_writes - w0), 32'd0);
        check_output("busy after reset release", 32'(c_busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/sd_frame_loader.md
SD_FRAME_LOADER -- requirements
Module: sd_frame_loader

Interface
REQ-001 SHALL have parameter PIX_W, default 16, pixel width in bits; multiple of 8; BPP = PIX_W/8.
REQ-002 SHALL have parameter ADDR_W, default 17, RAM word-address width.
REQ-003 SHALL have parameter NUM_SLOTS, default 4, number of image slots; SLOT_W = max(1, clog2(NUM_SLOTS)).
REQ-004 SHALL have parameter SLOT_PIXELS, default 19200, pixels per slot; NUM_SLOTS*SLOT_PIXELS <= 2^ADDR_W.
REQ-005 SHALL have parameter MSB_FIRST, default 1; 1 = first byte of a pixel lands in bits [PIX_W-1:PIX_W-8].
REQ-006 SHALL have parameter TIMEOUT_CYC, default 1000000, maximum idle cycles between bytes during a load.
REQ-007 clk  in  1  single clock; all logic on its rising edge.
REQ-008 rst_n  in  1  reset, asynchronous and active-low.
REQ-009 start  in  1  one-cycle load request.
REQ-010 slot_sel  in  SLOT_W  target slot, sampled with start.
REQ-011 abort  in  1  cancel the current load.
REQ-012 in_data  in  8  byte from the SD reader.
REQ-013 in_valid  in  1  in_data valid this cycle; no backpressure.
REQ-014 frame_sync  in  1  one-cycle pulse at display vertical blank.
REQ-015 ram_addr  out  ADDR_W  RAM write address.
REQ-016 ram_data  out  PIX_W  RAM write data.
REQ-017 ram_we  out  1  RAM write strobe.
REQ-018 busy  out  1  high in LOAD.
REQ-019 done  out  1  one-cycle pulse on load completion.
REQ-020 err  out  1  sticky timeout/range error flag.
REQ-021 loaded_mask  out  NUM_SLOTS  bit i set = slot i holds a complete image.
REQ-022 display_slot  out  SLOT_W  slot the display reads.

Function
REQ-023 SHALL implement the FSM IDLE, LOAD, DONE, ERR.
REQ-024 IDLE + start, slot_sel < NUM_SLOTS: SHALL go to LOAD, latch the slot, set base = slot*SLOT_PIXELS, clear pix_cnt, byte_idx and loaded_mask[slot].
REQ-025 IDLE or ERR + start, slot_sel >= NUM_SLOTS: SHALL go to ERR with err=1.
REQ-026 LOAD + in_valid: SHALL place the byte per MSB_FIRST and increment byte_idx, wrapping at BPP.
REQ-027 A byte completing a pixel, sampled at edge N: SHALL drive ram_we=1 for exactly one cycle after edge N, with ram_addr = base+pix_cnt and ram_data = the assembled pixel; then pix_cnt increments.
REQ-028 Completion of pixel SLOT_PIXELS-1: SHALL go to DONE; later in_valid bytes are dropped.
REQ-029 DONE: SHALL last one cycle; done=1, loaded_mask[slot] set, pending_slot = slot, pending_valid = 1; then IDLE.
REQ-030 LOAD + abort: SHALL go to IDLE next cycle; a pixel already completing still writes; no mask set; no done.
REQ-031 abort has priority over in_valid; start during LOAD or DONE is ignored.
REQ-032 LOAD: an idle counter SHALL reset on each in_valid; reaching TIMEOUT_CYC SHALL go to ERR with err=1.
REQ-033 ERR: SHALL hold until a valid start, which clears err and enters LOAD per REQ-024.
REQ-034 frame_sync with pending_valid=1 SHALL set display_slot = pending_slot and clear pending_valid; otherwise no change.
REQ-035 frame_sync in the same cycle as DONE SHALL act on the prior pending state; the new pending is kept for the next frame_sync.
REQ-036 in_valid outside LOAD SHALL be ignored.
REQ-037 Address arithmetic SHALL be ADDR_W-bit unsigned with no wrap, guaranteed by REQ-004.

Reset
REQ-038 While rst_n=0: FSM=IDLE, ram_we=0, ram_addr=0, ram_data=0, busy=0, done=0, err=0, loaded_mask=0, display_slot=0, pending_valid=0, all counters 0.
REQ-039 Reset asserted mid-load SHALL abandon the load with no further writes after deassertion.

Verification
REQ-040 Defaults; start, slot 2; 38400 bytes, byte 2k=0xAB, byte 2k+1=0xCD -> 19200 writes, addr 38400..57599, data 0xABCD, one ram_we cycle per pixel, done once, loaded_mask=4'b0100.
REQ-041 MSB_FIRST=0, PIX_W=24, slot 0; bytes 0x11,0x22,0x33 -> first write addr 0, data 0x332211, ram_we one cycle after the 0x33 edge.
REQ-042 Abort after 100 bytes in slot 1, previously loaded -> 50 writes, no done, loaded_mask[1]=0, busy falls next cycle.
REQ-043 TIMEOUT_CYC=16; stall 16 cycles after 3 bytes -> err=1, state ERR; then start slot 0 -> err=0, busy=1.
REQ-044 Slot 3 load completes while display_slot=0; frame_sync coincides with done -> display_slot stays 0; next frame_sync -> display_slot=3.
REQ-045 rst_n pulsed low mid-load at pixel 500 -> all outputs at reset values asynchronously; no ram_we after release until a new start.
